// File: rtl/sha256_msg_sequencer_if.sv
// Memory read port and SHA-256 compression-core handshake between the sequencer
// (master) and the memory/core pair (slave).
interface sha256_msg_sequencer_if #(
  parameter int ADDR_W = 16
);
  logic                mem_rd;
  logic [ADDR_W-1:0]   mem_addr;
  logic [31:0]         mem_rdata;
  logic                core_start;
  logic [15:0][31:0]   core_message;
  logic [7:0][31:0]    core_hin;
  logic [7:0][31:0]    core_hout;
  logic                core_done;

  modport master (
    output mem_rd, mem_addr, core_start, core_message, core_hin,
    input  mem_rdata, core_hout, core_done
  );
  modport slave (
    input  mem_rd, mem_addr, core_start, core_message, core_hin,
    output mem_rdata, core_hout, core_done
  );
endinterface

// File: rtl/sha256_msg_sequencer.sv
// Fetches a word message, pads it into 512-bit SHA-256 blocks and runs the compression
// core block by block. Optional SHA256_MIDSTATE_EN adds a caller-supplied initial IV.
module sha256_msg_sequencer #(
  parameter  int MAX_WORDS = 64,
  parameter  int ADDR_W    = 16,
  localparam int NW        = $clog2(MAX_WORDS + 1)
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_start,
  input  logic [ADDR_W-1:0]     i_base_addr,
  input  logic [NW-1:0]         i_msg_words,
`ifdef SHA256_MIDSTATE_EN
  input  logic [7:0][31:0]      i_iv_in,
  input  logic                  i_use_iv,
`endif
  sha256_msg_sequencer_if.master bus,
  output logic [7:0][31:0]      o_digest,
  output logic                  o_done,
  output logic                  o_busy
);
  localparam int NB_MAX = (MAX_WORDS + 18) / 16;
  localparam int BW     = $clog2(NB_MAX + 1);
  localparam int GW     = BW + 4;
  localparam logic [7:0][31:0] IV = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_ISSUE, S_WAIT} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic [NW-1:0]       r_n;
  logic [BW-1:0]       r_blk, r_last;
  logic [4:0]          r_k;
  logic                r_mem_rd, r_rd_q, r_core_start, r_done, r_busy;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0][31:0]   r_msg;
  logic [7:0][31:0]    r_hin, r_digest;

  logic [NW-1:0]       w_n_sat, w_nx_n;
  logic [BW-1:0]       w_nblk_m1, w_nx_blk;
  logic [3:0]          w_nx_k;
  logic [ADDR_W-1:0]   w_nx_base, w_nx_addr;
  logic [GW-1:0]       w_nx_g, w_g;
  logic                w_nx_rd;
  logic [31:0]         w_pad;
  logic [7:0][31:0]    w_iv0;

  assign w_n_sat   = (i_msg_words > NW'(MAX_WORDS)) ? NW'(MAX_WORDS) : i_msg_words;
  assign w_nblk_m1 = BW'((32'(w_n_sat) + 32'd18) / 32'd16 - 32'd1);

`ifdef SHA256_MIDSTATE_EN
  assign w_iv0 = i_use_iv ? i_iv_in : IV;
`else
  assign w_iv0 = IV;
`endif

  // Slot whose read strobe is launched at the coming edge: first slot of a new job,
  // first slot of the next block, or the following slot within FETCH.
  always_comb begin
    w_nx_blk  = r_blk;
    w_nx_k    = 4'(r_k + 5'd1);
    w_nx_n    = r_n;
    w_nx_base = r_base;
    if (r_state == S_IDLE) begin
      w_nx_blk  = '0;
      w_nx_k    = '0;
      w_nx_n    = w_n_sat;
      w_nx_base = i_base_addr;
    end else if (r_state == S_WAIT) begin
      w_nx_blk  = r_blk + BW'(1);
      w_nx_k    = '0;
    end
    w_nx_g    = {w_nx_blk, w_nx_k};
    w_nx_rd   = (32'(w_nx_g) < 32'(w_nx_n));
    w_nx_addr = w_nx_base + ADDR_W'(w_nx_g);
  end

  assign w_g = {r_blk, r_k[3:0]};

  // Padding for the current slot; the 0x80 marker can never land on slot 14/15 of the
  // last block because the block count always leaves room for the length word.
  always_comb begin
    w_pad = '0;
    if (32'(w_g) == 32'(r_n))
      w_pad = 32'h8000_0000;
    else if (r_blk == r_last && r_k[3:0] == 4'd15)
      w_pad = 32'(r_n) << 5;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_n          <= '0;
      r_blk        <= '0;
      r_last       <= '0;
      r_k          <= '0;
      r_mem_rd     <= 1'b0;
      r_rd_q       <= 1'b0;
      r_mem_addr   <= '0;
      r_core_start <= 1'b0;
      r_done       <= 1'b0;
      r_busy       <= 1'b0;
      r_msg        <= '0;
      r_hin        <= '0;
      r_digest     <= '0;
    end else begin
      r_rd_q       <= r_mem_rd;
      r_done       <= 1'b0;
      r_core_start <= 1'b0;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_base   <= i_base_addr;
          r_n      <= w_n_sat;
          r_last   <= w_nblk_m1;
          r_blk    <= '0;
          r_k      <= '0;
          r_hin    <= w_iv0;
          r_mem_rd <= w_nx_rd;
          if (w_nx_rd) r_mem_addr <= w_nx_addr;
          r_busy   <= 1'b1;
          r_state  <= S_FETCH;
        end
        S_FETCH: begin
          // Slot k-1's read data arrives now; slot k, if padding, is written directly.
          if (r_rd_q) r_msg[4'(r_k - 5'd1)] <= bus.mem_rdata;
          if (!r_k[4] && !r_mem_rd) r_msg[r_k[3:0]] <= w_pad;
          if (r_k < 5'd15) begin
            r_mem_rd <= w_nx_rd;
            if (w_nx_rd) r_mem_addr <= w_nx_addr;
          end else begin
            r_mem_rd <= 1'b0;
          end
          if (r_k == 5'd16) begin
            r_core_start <= 1'b1;
            r_state      <= S_ISSUE;
          end else begin
            r_k <= r_k + 5'd1;
          end
        end
        S_ISSUE: r_state <= S_WAIT;
        S_WAIT: if (bus.core_done) begin
          r_hin <= bus.core_hout;
          if (r_blk == r_last) begin
            r_digest <= bus.core_hout;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= S_IDLE;
          end else begin
            r_blk    <= w_nx_blk;
            r_k      <= '0;
            r_mem_rd <= w_nx_rd;
            if (w_nx_rd) r_mem_addr <= w_nx_addr;
            r_state  <= S_FETCH;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.mem_rd       = r_mem_rd;
  assign bus.mem_addr     = r_mem_addr;
  assign bus.core_start   = r_core_start;
  assign bus.core_message = r_msg;
  assign bus.core_hin     = r_hin;
  assign o_digest         = r_digest;
  assign o_done           = r_done;
  assign o_busy           = r_busy;
endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Bench for sha256_msg_sequencer: word memory, behavioural SHA-256 core and a digest
// scoreboard filled when each job is launched and drained on every done pulse.
module tb_sha256_msg_sequencer;
  localparam int MAX_WORDS = 64;
  localparam int ADDR_W    = 16;
  localparam int NW        = $clog2(MAX_WORDS + 1);
  typedef logic [7:0][31:0]  h_t;
  typedef logic [15:0][31:0] m_t;
  localparam h_t IV_H = {
    32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
    32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_n, i_start;
  logic [ADDR_W-1:0] i_base_addr;
  logic [NW-1:0]     i_msg_words;
  h_t                o_digest;
  logic              o_done, o_busy;
`ifdef SHA256_MIDSTATE_EN
  h_t                i_iv_in;
  logic              i_use_iv;
`endif

  sha256_msg_sequencer_if #(.ADDR_W(ADDR_W)) bus ();

  sha256_msg_sequencer #(.MAX_WORDS(MAX_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_start    (i_start),
    .i_base_addr(i_base_addr),
    .i_msg_words(i_msg_words),
`ifdef SHA256_MIDSTATE_EN
    .i_iv_in    (i_iv_in),
    .i_use_iv   (i_use_iv),
`endif
    .bus        (bus),
    .o_digest   (o_digest),
    .o_done     (o_done),
    .o_busy     (o_busy)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic h_t compress(input h_t hi, input m_t m);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    h_t ho;
    for (int i = 0; i < 16; i++) w[i] = m[i];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10)) + w[i-7] +
             (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-16];
    a = hi[0]; b = hi[1]; c = hi[2]; d = hi[3]; e = hi[4]; f = hi[5]; g = hi[6]; hh = hi[7];
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    ho[0] = hi[0] + a; ho[1] = hi[1] + b; ho[2] = hi[2] + c; ho[3] = hi[3] + d;
    ho[4] = hi[4] + e; ho[5] = hi[5] + f; ho[6] = hi[6] + g; ho[7] = hi[7] + hh;
    return ho;
  endfunction

  // Big-endian digest constant (first word leftmost) to word-indexed form.
  function automatic h_t be2h(input logic [255:0] be);
    h_t h;
    for (int i = 0; i < 8; i++) h[i] = be[255 - 32*i -: 32];
    return h;
  endfunction

  logic [31:0] mem [0:1023];

  function automatic h_t ref_digest(input int base, input int n);
    h_t h = IV_H;
    m_t m;
    int nb = (n + 18) / 16;
    for (int b = 0; b < nb; b++) begin
      for (int k = 0; k < 16; k++) begin
        int g = 16*b + k;
        if (g < n)                         m[k] = mem[(base + g) % 1024];
        else if (g == n)                   m[k] = 32'h8000_0000;
        else if (b == nb - 1 && k == 15)   m[k] = 32'(n * 32);
        else                               m[k] = 32'h0;
      end
      h = compress(h, m);
    end
    return h;
  endfunction

  logic [31:0] r_rdata;
  always @(posedge clk) if (bus.mem_rd) r_rdata <= mem[bus.mem_addr[9:0]];
  assign bus.mem_rdata = r_rdata;

  // Behavioural compression core with programmable latency.
  int   lat_cfg = 3;
  logic c_act, c_done_r, stray;
  int   c_cnt;
  h_t   c_res, c_hin, c_hout;
  m_t   c_msg;
  h_t   hin_log[$], hout_log[$];
  m_t   msg_log[$];
  assign bus.core_done = c_done_r | stray;
  assign bus.core_hout = c_hout;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c_act    <= 1'b0;
      c_done_r <= 1'b0;
      c_cnt    <= 0;
      c_hout   <= '0;
    end else begin
      c_done_r <= 1'b0;
      if (bus.core_start) begin
        c_act <= 1'b1;
        c_cnt <= lat_cfg;
        c_msg <= bus.core_message;
        c_hin <= bus.core_hin;
        c_res <= compress(bus.core_hin, bus.core_message);
        msg_log.push_back(bus.core_message);
        hin_log.push_back(bus.core_hin);
        hout_log.push_back(compress(bus.core_hin, bus.core_message));
      end else if (c_act) begin
        if (c_cnt == 0) begin
          c_act    <= 1'b0;
          c_done_r <= 1'b1;
          c_hout   <= c_res;
        end else begin
          c_cnt <= c_cnt - 1;
        end
      end
    end
  end

  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int   n_rd, n_cs, n_done = 0, fcnt, t_issue, unstable;
  int   rd_addr[$], rd_cyc[$];
  logic seen_cs, prev_done = 1'b0;
  h_t   exp_q[$];

  always @(negedge clk) begin
    if (bus.mem_rd) begin
      n_rd++;
      rd_addr.push_back(int'(bus.mem_addr));
      rd_cyc.push_back(cyc);
    end
    if (bus.core_start) n_cs++;
    if (bus.core_start && !seen_cs) begin
      seen_cs = 1'b1;
      t_issue = fcnt;
    end else if (o_busy && !seen_cs) fcnt++;
    if (c_act && (bus.core_message !== c_msg || bus.core_hin !== c_hin)) unstable++;
    if (o_done) begin
      n_done++;
      chk("done_width", 512'(prev_done), 512'(0));
      if (exp_q.size() == 0) chk("unexpected_done", 512'(1), 512'(0));
      else                   chk("digest", 512'(o_digest), 512'(exp_q.pop_front()));
    end
    prev_done = o_done;
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr();
    n_rd = 0; n_cs = 0; fcnt = 0; t_issue = -1; unstable = 0; seen_cs = 1'b0;
    rd_addr.delete(); rd_cyc.delete();
    msg_log.delete(); hin_log.delete(); hout_log.delete();
  endtask

  task automatic go(input int base, input int n);
    i_base_addr = ADDR_W'(base);
    i_msg_words = NW'(n);
    i_start     = 1'b1;
    tick();
    i_start     = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int d0 = n_done;
    int t  = 0;
    while (n_done == d0 && t < 3000) begin tick(); t++; end
    chk(tag, 512'(n_done != d0), 512'(1));
  endtask

  task automatic job(input int base, input int n, input h_t exp);
    clr();
    exp_q.push_back(exp);
    go(base, n);
    wait_done("job_timeout");
    chk("stable_during_core", 512'(unstable), 512'(0));
  endtask

  initial begin
    h_t   empty_h, abcd_h;
    m_t   em;
    int   t;
    empty_h = be2h(256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855);
    abcd_h  = be2h(256'h88d4266fd4e6338d13b845fcf289579d209c897823b9217da3e161936f031589);
    reset_n = 1'b0; i_start = 1'b0; i_base_addr = '0; i_msg_words = '0; stray = 1'b0;
`ifdef SHA256_MIDSTATE_EN
    i_use_iv = 1'b0; i_iv_in = '0;
`endif
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[10] = 32'h6162_6364;
    repeat (3) tick();

    chk("rst_busy",     512'(o_busy),           512'(0));
    chk("rst_done",     512'(o_done),           512'(0));
    chk("rst_mem_rd",   512'(bus.mem_rd),       512'(0));
    chk("rst_mem_addr", 512'(bus.mem_addr),     512'(0));
    chk("rst_cstart",   512'(bus.core_start),   512'(0));
    chk("rst_message",  512'(bus.core_message), 512'(0));
    chk("rst_hin",      512'(bus.core_hin),     512'(0));
    chk("rst_digest",   512'(o_digest),         512'(0));
    reset_n = 1'b1;
    repeat (2) tick();

    // Empty message: single all-padding block.
    job(0, 0, empty_h);
    em = '0; em[0] = 32'h8000_0000;
    chk("n0_cstarts", 512'(n_cs), 512'(1));
    chk("n0_reads",   512'(n_rd), 512'(0));
    chk("n0_block",   512'(msg_log[0]), 512'(em));
    chk("n0_hin_iv",  512'(hin_log[0]), 512'(IV_H));

    job(10, 1, abcd_h);
    chk("n1_cstarts", 512'(n_cs), 512'(1));
    chk("n1_reads",   512'(n_rd), 512'(1));

    job(200, 13, ref_digest(200, 13));
    chk("n13_cstarts", 512'(n_cs), 512'(1));
    chk("n13_w13",     512'(msg_log[0][13]), 512'(32'h8000_0000));
    chk("n13_w15",     512'(msg_log[0][15]), 512'(32'd416));

    job(300, 14, ref_digest(300, 14));
    em = '0; em[15] = 32'h0000_01c0;
    chk("n14_cstarts",  512'(n_cs), 512'(2));
    chk("n14_b0_w14",   512'(msg_log[0][14]), 512'(32'h8000_0000));
    chk("n14_b0_w15",   512'(msg_log[0][15]), 512'(0));
    chk("n14_b1_block", 512'(msg_log[1]), 512'(em));
    chk("n14_b1_hin",   512'(hin_log[1]), 512'(hout_log[0]));

    // N=3: read timing, FETCH length, and a start pulse while waiting on the core.
    lat_cfg = 8;
    clr();
    exp_q.push_back(ref_digest(100, 3));
    go(100, 3);
    t = 0;
    while (!seen_cs && t < 100) begin tick(); t++; end
    chk("n3_issue_seen", 512'(seen_cs), 512'(1));
    tick();
    i_base_addr = '0; i_msg_words = '0; i_start = 1'b1;
    tick();
    i_start = 1'b0;
    wait_done("n3_timeout");
    repeat (40) tick();
    chk("n3_cstarts",  512'(n_cs), 512'(1));
    chk("n3_idle",     512'(o_busy), 512'(0));
    chk("n3_reads",    512'(n_rd), 512'(3));
    chk("n3_addr0",    512'(rd_addr[0]), 512'(100));
    chk("n3_addr1",    512'(rd_addr[1]), 512'(101));
    chk("n3_addr2",    512'(rd_addr[2]), 512'(102));
    chk("n3_rd_cyc1",  512'(rd_cyc[1] - rd_cyc[0]), 512'(1));
    chk("n3_rd_cyc2",  512'(rd_cyc[2] - rd_cyc[1]), 512'(1));
    chk("n3_fetch_len", 512'(t_issue), 512'(17));
    lat_cfg = 3;

    // Reset while block 1 of an N=20 job is with the core.
    clr();
    go(400, 20);
    t = 0;
    while (n_cs < 2 && t < 200) begin tick(); t++; end
    chk("rst_mid_reached", 512'(n_cs), 512'(2));
    tick();
    reset_n = 1'b0;
    #1;
    chk("rstmid_busy",   512'(o_busy),         512'(0));
    chk("rstmid_cstart", 512'(bus.core_start), 512'(0));
    chk("rstmid_done",   512'(o_done),         512'(0));
    chk("rstmid_digest", 512'(o_digest),       512'(0));
    chk("rstmid_hin",    512'(bus.core_hin),   512'(0));
    tick();
    reset_n = 1'b1;
    repeat (2) tick();
    job(0, 0, empty_h);

    // Stray core_done while idle must be ignored.
    stray = 1'b1;
    tick();
    stray = 1'b0;
    repeat (3) tick();
    chk("stray_busy", 512'(o_busy), 512'(0));

    job(600, 64, ref_digest(600, 64));
    chk("n64_cstarts", 512'(n_cs), 512'(5));
    job(500, 100, ref_digest(500, 64));
    chk("sat_cstarts", 512'(n_cs), 512'(5));
    chk("sat_reads",   512'(n_rd), 512'(64));

`ifdef SHA256_MIDSTATE_EN
    i_use_iv = 1'b1;
    i_iv_in  = IV_H;
    job(10, 1, abcd_h);
    i_use_iv = 1'b0;
`endif

    repeat (5) tick();
    chk("scoreboard_empty", 512'(exp_q.size()), 512'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, observed running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Initiator side of the SHA-256 compression core handshake. It reads a word-granular message from a synchronous word memory and builds FIPS 180-4 padded 512-bit blocks. For each block it issues start to the compression core, waits for done, and feeds the core's hash output back as the next block's hash input. After the last block it presents the 256-bit digest with a one-cycle done pulse.

Parameters:
MAX_WORDS, 64, maximum message length in 32-bit words; longer requests saturate to this value.
ADDR_W, 16, memory word-address width.

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
start  in  1  begin hashing; sampled only in IDLE
base_addr  in  ADDR_W  word address of message word 0
msg_words  in  $clog2(MAX_WORDS+1)  message length in words (0 allowed)
mem_rd  out  1  memory read strobe
mem_addr  out  ADDR_W  memory read address
mem_rdata  in  32  read data, valid exactly 1 cycle after mem_rd
core_start  out  1  one-cycle start pulse to compression core
core_message  out  32x16  block words; index 0 is the first word of the block
core_hin  out  32x8  chaining value to core
core_hout  in  32x8  core result; valid in the cycle core_done=1
core_done  in  1  core completion pulse
digest  out  32x8  final hash; holds until the next completed job
done  out  1  one-cycle pulse when digest is updated
busy  out  1  high in every state except IDLE

Behaviour:
- Reset is asynchronous, active-low, on reset_n; clock is clk.
- Reset values: state=IDLE; mem_rd, core_start, done, busy = 0; mem_addr, core_message, core_hin, digest = 0.
- On start in IDLE, latch base_addr and msg_words (N, saturated to MAX_WORDS).
- Block count B = (N+3+15)/16, integer division. Block index b runs 0..B-1.
- Chaining value is initialised to the SHA-256 IV: 6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19.
- Global word index g = 16*b + k, for k = 0..15:
  - g < N: mem word at base_addr+g.
  - g == N: 32'h80000000.
  - Last block, k=14: 32'h0 (upper length word; N*32 always < 2^32).
  - Last block, k=15: N*32 (bit length).
  - Otherwise: 0.
- FSM states:
  - IDLE: start → FETCH, with b=0 and k=0.
  - FETCH: one word slot per cycle for k=0..15.
    - When g<N, assert mem_rd with mem_addr=base_addr+g. Capture mem_rdata into core_message[k] one cycle later.
    - Padding words are written directly, with no read.
    - Leave FETCH the cycle after slot 15 has been captured. FETCH therefore lasts exactly 17 cycles, whatever the mix of reads and padding.
  - ISSUE: core_start=1 for exactly one cycle; core_message and core_hin are stable from this cycle until core_done. Next state WAIT.
  - WAIT: hold until core_done.
    - On core_done: latch core_hout into core_hin.
    - If b<B-1: b++, go to FETCH.
    - Otherwise: digest<=core_hout, done=1 for one cycle, go to IDLE.
- core_done outside WAIT is ignored.
- start while busy is ignored; it does not queue.
- done and a new start may coincide only once the FSM is in IDLE. start in the cycle after done begins a new job.
- Reset mid-job aborts immediately and restores all reset values. The core must be reset by the same reset_n.
- Boundaries:
  - N=0: one block; word 0 = 80000000, all other words 0 except k=15 = 0.
  - N=13: one block; word 13 = 80000000.
  - N=14: two blocks; the 80000000 word is in block 0, and the length is in block 1.
  - N=MAX_WORDS=64: five blocks.

Optional Feature:
SHA256_MIDSTATE_EN
- Defined: adds input port iv_in (32x8) and input use_iv (1), both sampled with start. If use_iv=1, the initial chaining value is iv_in instead of the standard IV. This supports precomputed midstates, as in bitcoin header hashing. Padding length still counts only N words; the prefix length is then the caller's responsibility, by passing an adjusted N.
- Undefined: neither port exists, and the standard IV is always used.

Test Plan:
- N=0, start → one core_start pulse, digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855, done high for exactly 1 cycle.
- N=1, mem[base]=61626364 ("abcd") → digest = 88d4266f d4e6338d 13b845fc f289579d 209c8978 23b9217d a3e16193 6f031589.
- N=13 vs N=14 → exactly 1 vs 2 core_start pulses. For N=14, block 1 message = all zero except word 15 = 000001c0; core_hin of block 1 equals block 0's core_hout.
- N=3, base_addr=100 → mem_rd asserted exactly 3 times, at addresses 100, 101, 102 on consecutive cycles; core_start asserted 17 cycles after leaving IDLE; start pulsed during WAIT has no effect.
- Deassert reset_n during WAIT of block 1 of N=20 → busy, core_start, and done go to 0 at once. A following N=0 job then yields the empty-string digest.
- With SHA256_MIDSTATE_EN: use_iv=1, iv_in = the IV constants → digest identical to the use_iv=0 result for the same message.
